// File: rtl/riscv_pkg.sv
// Fetch-stage shared constants: FSM state encodings, PC step, alignment mask.
// No timing or flow-control behaviour of its own.
package riscv_pkg;

  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FULL  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int unsigned PC_INCR    = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register with synchronous active-high reset and load enable.
// Updates one cycle after REG_Load; holds its value otherwise (no backpressure).
module fetch_pc_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             REG_Clk,
  input  logic             REG_Reset,
  input  logic             REG_Load,
  input  logic [WIDTH-1:0] REG_Data,
  output logic [WIDTH-1:0] REG_Q
);

  always_ff @(posedge REG_Clk) begin
    if (REG_Reset) begin
      REG_Q <= RESET_VAL;
    end else if (REG_Load) begin
      REG_Q <= REG_Data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect flush, misaligned-target halt.
// REQ->WAIT->FULL is 3 cycles per instruction; FULL holds the pair until FETCH_Ready_In.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned                  FETCH_DATA_WIDTH = 32,
  parameter logic [FETCH_DATA_WIDTH-1:0]  FETCH_RESET_PC   = '0
) (
  input  logic                        FETCH_Clk,
  input  logic                        FETCH_Reset,
  input  logic                        FETCH_Redirect_In,
  input  logic [FETCH_DATA_WIDTH-1:0] FETCH_RedirectPC_InBUS,
  output logic                        FETCH_MemReq_Out,
  output logic [FETCH_DATA_WIDTH-1:0] FETCH_MemAddr_OutBUS,
  input  logic                        FETCH_MemAck_In,
  input  logic                        FETCH_MemValid_In,
  input  logic [FETCH_DATA_WIDTH-1:0] FETCH_MemData_InBUS,
  output logic                        FETCH_Valid_Out,
  output logic [FETCH_DATA_WIDTH-1:0] FETCH_Instr_OutBUS,
  output logic [FETCH_DATA_WIDTH-1:0] FETCH_PC_OutBUS,
  input  logic                        FETCH_Ready_In,
  output logic                        FETCH_Misaligned_Out
);

  logic [2:0]                  state_q;
  logic [2:0]                  state_d;
  logic [FETCH_DATA_WIDTH-1:0] pc_q;
  logic [FETCH_DATA_WIDTH-1:0] pc_d;
  logic                        pc_load;
  logic                        capture;
  logic [FETCH_DATA_WIDTH-1:0] instr_q;
  logic [FETCH_DATA_WIDTH-1:0] pc_out_q;
  logic                        misaligned_q;
  logic                        redirect_live;
  logic                        redirect_ok;
  logic                        redirect_bad;

  // Redirects are dead once halted; only reset leaves S_HALT.
  assign redirect_live = FETCH_Redirect_In && (state_q != S_HALT);
  assign redirect_ok   = redirect_live &&  is_aligned(FETCH_RedirectPC_InBUS[1:0]);
  assign redirect_bad  = redirect_live && !is_aligned(FETCH_RedirectPC_InBUS[1:0]);

  fetch_pc_reg #(
    .WIDTH     (FETCH_DATA_WIDTH),
    .RESET_VAL (FETCH_RESET_PC)
  ) u_pc_reg (
    .REG_Clk   (FETCH_Clk),
    .REG_Reset (FETCH_Reset),
    .REG_Load  (pc_load),
    .REG_Data  (pc_d),
    .REG_Q     (pc_q)
  );

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_d    = pc_q;
    capture = 1'b0;
    if (redirect_bad) begin
      state_d = S_HALT;
    end else if (redirect_ok) begin
      pc_load = 1'b1;
      pc_d    = FETCH_RedirectPC_InBUS;
      // A request already accepted by memory must have its response drained.
      case (state_q)
        S_REQ:   state_d = FETCH_MemAck_In   ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = FETCH_MemValid_In ? S_REQ   : S_DRAIN;
        S_DRAIN: state_d = FETCH_MemValid_In ? S_REQ   : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (FETCH_MemAck_In) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (FETCH_MemValid_In) begin
            capture = 1'b1;
            state_d = S_FULL;
          end
        end
        S_DRAIN: begin
          if (FETCH_MemValid_In) state_d = S_REQ;
        end
        S_FULL: begin
          if (FETCH_Ready_In) begin
            pc_load = 1'b1;
            pc_d    = pc_q + FETCH_DATA_WIDTH'(PC_INCR);
            state_d = S_REQ;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge FETCH_Clk) begin
    if (FETCH_Reset) begin
      state_q      <= S_REQ;
      instr_q      <= '0;
      pc_out_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_q  <= FETCH_MemData_InBUS;
        pc_out_q <= pc_q;
      end
      if (redirect_bad) misaligned_q <= 1'b1;
    end
  end

  assign FETCH_MemReq_Out     = (state_q == S_REQ) && !FETCH_Reset;
  assign FETCH_MemAddr_OutBUS = pc_q;
  assign FETCH_Valid_Out      = (state_q == S_FULL);
  assign FETCH_Instr_OutBUS   = instr_q;
  assign FETCH_PC_OutBUS      = pc_out_q;
  assign FETCH_Misaligned_Out = misaligned_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then randomized memory/redirect/ready traffic,
// with a negedge monitor checking against an expected-PC queue and output invariants.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic [31:0] rpc;
  logic        ack;
  logic        mv;
  logic [31:0] md;
  logic        rdy;
  logic        req;
  logic [31:0] addr;
  logic        vld;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic        mis;

  int vectors     = 0;
  int miscompares = 0;
  int deliveries  = 0;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .FETCH_DATA_WIDTH (32),
    .FETCH_RESET_PC   (RESET_PC)
  ) dut (
    .FETCH_Clk              (clk),
    .FETCH_Reset            (rst),
    .FETCH_Redirect_In      (redir),
    .FETCH_RedirectPC_InBUS (rpc),
    .FETCH_MemReq_Out       (req),
    .FETCH_MemAddr_OutBUS   (addr),
    .FETCH_MemAck_In        (ack),
    .FETCH_MemValid_In      (mv),
    .FETCH_MemData_InBUS    (md),
    .FETCH_Valid_Out        (vld),
    .FETCH_Instr_OutBUS     (instr),
    .FETCH_PC_OutBUS        (pc_o),
    .FETCH_Ready_In         (rdy),
    .FETCH_Misaligned_Out   (mis)
  );

  // Instruction memory contents as a pure function of address; word 0 is a NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          m_armed      = 1'b0;
  bit          m_prev_rst   = 1'b0;
  bit          m_prev_redir = 1'b0;
  bit          m_halted     = 1'b0;
  bit          m_outst      = 1'b0;
  bit          m_last_vld   = 1'b0;
  bit          m_last_took  = 1'b1;
  logic [31:0] m_last_instr = '0;
  logic [31:0] m_last_pc    = '0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_armed) begin
        if (m_prev_rst) begin
          chk1("rst_valid", vld, 1'b0);
          chk("rst_instr", instr, 32'h0);
          chk("rst_pc_out", pc_o, 32'h0);
          chk1("rst_misaligned", mis, 1'b0);
          chk("rst_addr", addr, RESET_PC);
        end
        if (rst) begin
          chk1("req_in_reset", req, 1'b0);
        end else begin
          if (m_prev_rst) chk1("req_after_reset", req, 1'b1);
          chk1("misaligned_flag", mis, m_halted);
          if (m_halted) begin
            chk1("halt_req", req, 1'b0);
            chk1("halt_valid", vld, 1'b0);
          end
          if (req) chk1("one_outstanding", m_outst, 1'b0);
          if (vld) chk1("no_req_while_full", req, 1'b0);
          if (m_prev_redir) chk1("valid_after_redirect", vld, 1'b0);
          if (vld && m_last_vld && !m_last_took) begin
            chk("hold_instr", instr, m_last_instr);
            chk("hold_pc", pc_o, m_last_pc);
          end
          if (!m_halted) begin
            if (redir) begin
              if (rpc[1:0] != 2'b00) begin
                m_halted = 1'b1;
              end else begin
                exp_q.delete();
                exp_q.push_back(exp_t'{rpc, mem_word(rpc)});
              end
            end else if (vld && rdy) begin
              chk("exp_queue_depth", 32'(exp_q.size()), 32'd1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("deliver_pc", pc_o, e.pc);
                chk("deliver_instr", instr, e.instr);
                exp_q.push_back(exp_t'{e.pc + 32'd4, mem_word(e.pc + 32'd4)});
                deliveries++;
              end
            end
          end
        end
      end
      m_last_took  = rst || redir || (vld && rdy);
      m_last_vld   = vld;
      m_last_instr = instr;
      m_last_pc    = pc_o;
      m_prev_redir = !rst && redir;
      if (rst)                m_outst = 1'b0;
      else if (mv && m_outst) m_outst = 1'b0;
      else if (req && ack)    m_outst = 1'b1;
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(exp_t'{RESET_PC, mem_word(RESET_PC)});
        m_halted = 1'b0;
      end
      m_prev_rst = rst;
      m_armed    = m_armed | rst;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit rd, input logic [31:0] t, input bit a,
                     input bit v, input logic [31:0] d, input bit y);
    @(posedge clk);
    #1;
    rst = r; redir = rd; rpc = t; ack = a; mv = v; md = d; rdy = y;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic serve(input logic [31:0] a);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("serve_req", req, 1'b1);
    chk("serve_addr", addr, a);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, mem_word(a), 1'b0);
    chk1("serve_wait_valid", vld, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk1("serve_valid", vld, 1'b1);
    chk("serve_pc", pc_o, a);
    chk("serve_instr", instr, mem_word(a));
  endtask

  initial begin : driver
    bit          pending;
    bit          l_acc;
    bit          l_mv;
    bit          l_rst;
    logic [31:0] p_addr;
    logic [31:0] l_addr;
    rst = 1'b1; redir = 1'b0; rpc = '0; ack = 1'b0; mv = 1'b0; md = '0; rdy = 1'b0;
    pending = 1'b0; l_acc = 1'b0; l_mv = 1'b0; l_rst = 1'b1; p_addr = '0; l_addr = '0;

    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("reset_req_low", req, 1'b0);

    // Boot fetch: immediate ack, NOP returned, decode ready.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk1("boot_req", req, 1'b1);
    chk("boot_addr", addr, RESET_PC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk1("boot_valid", vld, 1'b1);
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_instr", instr, 32'h0000_0013);
    idle();
    chk1("next_req", req, 1'b1);
    chk("next_addr", addr, 32'h0000_0004);

    // Decode stalls for five cycles in FULL.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h4), 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk1("stall_valid", vld, 1'b1);
      chk("stall_instr", instr, mem_word(32'h4));
      chk("stall_pc", pc_o, 32'h4);
      chk1("stall_no_req", req, 1'b0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect in WAIT; stale response arrives in DRAIN.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk1("drain_req", req, 1'b0);
    chk1("drain_valid", vld, 1'b0);
    idle();
    chk1("post_drain_req", req, 1'b1);
    chk("post_drain_addr", addr, 32'h0000_0100);
    serve(32'h0000_0100);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
    serve(32'hFFFF_FFFC);
    serve(32'h0000_0000);

    // Redirect in WAIT coinciding with the response.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle();
    chk1("wait_redir_valid", vld, 1'b0);
    chk("wait_redir_addr", addr, 32'h0000_0040);
    serve(32'h0000_0040);

    // Redirect in FULL with decode ready: held instruction dropped.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h44), 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    chk1("full_redir_valid", vld, 1'b0);
    chk("full_redir_addr", addr, 32'h0000_0080);
    serve(32'h0000_0080);

    // Misaligned redirect halts until reset.
    cyc(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk1("halt_mis", mis, 1'b1);
      chk1("halt_no_req", req, 1'b0);
    end
    cyc(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0, 1'b1);
    chk1("halt_ignores_redirect", mis, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    chk1("unhalt_mis", mis, 1'b0);
    chk1("unhalt_req", req, 1'b1);
    chk("unhalt_addr", addr, RESET_PC);

    // Reset while waiting; late response after release ignored.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk1("late_rsp_req", req, 1'b1);
    chk("late_rsp_addr", addr, RESET_PC);
    idle();
    chk1("late_rsp_valid", vld, 1'b0);
    chk1("late_rsp_req_held", req, 1'b1);
    serve(RESET_PC);

    // Randomized traffic with a responsive memory model.
    l_rst = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit          r, rd, a, v, y;
      logic [31:0] t, d;
      int unsigned sel;
      if (l_rst)      pending = 1'b0;
      else if (l_mv)  pending = 1'b0;
      else if (l_acc) begin
        pending = 1'b1;
        p_addr  = l_addr;
      end
      r   = mis ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      t   = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      sel = $urandom_range(0, 9);
      if (sel == 0)      t[1:0] = 2'($urandom_range(1, 3));
      else if (sel == 1) t = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(2, 3)), 2'b00};
      a = ($urandom_range(0, 2) != 0);
      v = pending ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      d = pending ? mem_word(p_addr) : $urandom();
      y = ($urandom_range(0, 1) == 1);
      cyc(r, rd, t, a, v, d, y);
      l_acc  = req && a && !r;
      l_addr = addr;
      l_mv   = v && pending;
      l_rst  = r;
    end
    idle();
    idle();
    chk1("random_deliveries_seen", deliveries >= 50, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
